dpll_backtrack_ctrl: RTL and testbench
======================================

# dpll_backtrack_ctrl

Decision and backtrack controller for the SAT datapath. It sits directly upstream of the boolean assignment stack (`Stack_bool`), which holds one value bit per decision level. The controller assigns variables in fixed order (variable index = decision level) and hands each assignment to the clause evaluator. On a conflict it performs chronological backtracking by popping and flipping stack entries, and it reports SAT, UNSAT or error.

## Interface
- NUM_VARS, 16, number of variables; must be ≤ `bool_stack_size` from `common`.
- VAR_W, 5, width of the variable-index and level buses; ≥ $clog2(NUM_VARS+1).
- SETTLE, 2, cycles waited after any push/pop before sampling `stk_front`/`stk_empty`; ≥ 2.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a solve; honoured only in IDLE, SAT, UNSAT or ERR.
- eval_done  in  1  evaluator response strobe, one cycle.
- conflict  in  1  valid with `eval_done`; 1 means the current partial assignment falsifies a clause.
- stk_front  in  1  stack top bit.
- stk_empty  in  1  stack empty flag.
- stk_full  in  1  stack full flag.
- stk_clr  out  1  one-cycle stack clear; top level ORs it into the stack reset.
- stk_wr_en  out  1  push strobe, one cycle.
- stk_pop  out  1  pop strobe, one cycle.
- stk_din  out  1  bit to push.
- eval_req  out  1  one-cycle strobe: evaluate `var_idx`=`var_val`.
- unassign  out  1  one-cycle strobe: evaluator retracts `var_idx`.
- var_idx  out  VAR_W  variable index for `eval_req`/`unassign`.
- var_val  out  1  assigned value for `eval_req`.
- level  out  VAR_W  current decision depth, equal to the stack occupancy.
- busy  out  1  high in every state except IDLE, SAT, UNSAT and ERR.
- sat, unsat, err  out  1 each  sticky result flags, cleared on `start` or `reset`.

## Operation
- States: IDLE, CLEAR, WAIT, DECIDE, EVAL, BT_CHECK, BT_POP, FLIP, SAT, UNSAT, ERR.
- WAIT is a SETTLE-cycle down-counter. It carries a return state and performs no other action.
- IDLE/SAT/UNSAT/ERR + `start`:
  - clear the result flags and set `level`←0;
  - go to CLEAR, which pulses `stk_clr` for 1 cycle, then WAIT → DECIDE.
- DECIDE:
  - if `level`==NUM_VARS → SAT;
  - else if `stk_full` → ERR;
  - else pulse `stk_wr_en` with `stk_din`=0, set `var_idx`←`level`, `var_val`←0, `level`←`level`+1, then WAIT → EVAL.
- EVAL:
  - pulse `eval_req` on the first cycle, then hold until `eval_done`;
  - on `conflict`=0 → DECIDE;
  - on `conflict`=1 → BT_CHECK.
- BT_CHECK:
  - if `stk_empty` → UNSAT;
  - else if `stk_front`==1 → BT_POP;
  - else (`stk_front`==0) → FLIP.
- BT_POP:
  - pulse `stk_pop` and `unassign` with `var_idx`=`level`-1;
  - set `level`←`level`-1, then WAIT → BT_CHECK.
- FLIP, two actions separated by WAIT:
  - first, pulse `stk_pop` and `unassign` for `var_idx`=`level`-1, then WAIT;
  - then pulse `stk_wr_en` with `stk_din`=1, `var_val`←1;
  - `level` is unchanged overall; then WAIT → EVAL.
- Strobe exclusivity: `stk_wr_en` and `stk_pop` are never high in the same cycle. Only one of `eval_req`/`unassign` is high per cycle.
- `eval_done` outside EVAL is ignored, and `start` while `busy` is ignored.
- `stk_full` is sampled only in DECIDE. It is legal only when NUM_VARS > `bool_stack_size`, a misconfiguration that drives ERR.
- `level` saturates conceptually: it never underflows, because BT_POP is entered only when `stk_empty`=0.

## Timing
- All outputs registered; all state changes on the posedge of `clock`.
- Reset values: every output 0; state IDLE; `level` 0. Reset wins over every other input in the same cycle.
- Reset mid-operation returns to IDLE within one cycle. The top-level reset OR also clears the stack, so stack and `level` stay consistent.
- From `start` at edge N:
  - `stk_clr` high in cycle N+1;
  - first `stk_wr_en` in cycle N+2+SETTLE;
  - first `eval_req` in cycle N+3+2·SETTLE.
- `eval_done` may arrive one or more cycles after `eval_req`, never in the same cycle.
- The next DECIDE push occurs the cycle after `eval_done` with `conflict`=0.
- Each pop or push is followed by exactly SETTLE idle cycles before the stack flags are sampled.
- `sat`/`unsat`/`err` rise the cycle after the deciding state is entered and hold until `start` or `reset`.

## Test plan
- No conflicts, NUM_VARS=3, evaluator always answers `conflict`=0:
  - `eval_req` for (0,0),(1,0),(2,0);
  - `sat`=1 and `level`=3; stack holds 0,0,0.
- Single conflict on (1,0), NUM_VARS=3:
  - one `unassign` of var 1, then `eval_req` (1,1), then (2,0);
  - `sat`=1 with stack 0,1,0.
- Always-conflict evaluator, NUM_VARS=2:
  - sequence is `eval_req` (0,0), `unassign` 0, `eval_req` (0,1), `unassign` 0;
  - `unsat`=1 and `level`=0.
- Deep backtrack, NUM_VARS=3, conflict on var2 for both values and on (1,0) only when var0=0:
  - the pop chain unwinds to var0 and flips it to 1;
  - the run reaches `sat` with stack 1,0,0.
- Reset asserted for 1 cycle while in EVAL at `level`=2:
  - next cycle all outputs are 0 and state is IDLE;
  - a later `eval_done` is ignored;
  - a new `start` replays from var 0.
- `start` pulsed while `busy` has no effect.
- `start` after UNSAT clears `unsat` and restarts with `stk_clr`.

Source files
------------

// File: rtl/dpll_backtrack_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dpll_backtrack_ctrl: chronological DPLL decide/backtrack sequencer, Rev 1.0 |
// +---------------------------------------------------------------------------+
module dpll_backtrack_ctrl #(
  parameter int NUM_VARS = 16,
  parameter int VAR_W    = 5,
  parameter int SETTLE   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             eval_done,
  input  logic             conflict,
  input  logic             stk_front,
  input  logic             stk_empty,
  input  logic             stk_full,
  output logic             stk_clr,
  output logic             stk_wr_en,
  output logic             stk_pop,
  output logic             stk_din,
  output logic             eval_req,
  output logic             unassign,
  output logic [VAR_W-1:0] var_idx,
  output logic             var_val,
  output logic [VAR_W-1:0] level,
  output logic             busy,
  output logic             sat,
  output logic             unsat,
  output logic             err
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLEAR    = 4'd1;
  localparam logic [3:0] S_WAIT     = 4'd2;
  localparam logic [3:0] S_DECIDE   = 4'd3;
  localparam logic [3:0] S_EVAL     = 4'd4;
  localparam logic [3:0] S_BT_CHECK = 4'd5;
  localparam logic [3:0] S_BT_POP   = 4'd6;
  localparam logic [3:0] S_FLIP     = 4'd7;
  localparam logic [3:0] S_SAT      = 4'd8;
  localparam logic [3:0] S_UNSAT    = 4'd9;
  localparam logic [3:0] S_ERR      = 4'd10;

  logic [3:0]       state, state_next, ret, ret_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req_sent, req_sent_next, flip_ph, flip_ph_next;
  logic [VAR_W-1:0] level_next, var_idx_next;
  logic             var_val_next, clr_next, wr_next, pop_next, din_next;
  logic             req_next, unas_next, busy_next, sat_next, unsat_next, err_next;
  logic             at_end;

  assign at_end = (level == VAR_W'(NUM_VARS));

  function automatic logic is_term(input logic [3:0] s);
    return (s == S_IDLE) || (s == S_SAT) || (s == S_UNSAT) || (s == S_ERR);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ret       <= S_IDLE;
      cnt       <= '0;
      req_sent  <= 1'b0;
      flip_ph   <= 1'b0;
      level     <= '0;
      var_idx   <= '0;
      var_val   <= 1'b0;
      stk_clr   <= 1'b0;
      stk_wr_en <= 1'b0;
      stk_pop   <= 1'b0;
      stk_din   <= 1'b0;
      eval_req  <= 1'b0;
      unassign  <= 1'b0;
      busy      <= 1'b0;
      sat       <= 1'b0;
      unsat     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      ret       <= ret_next;
      cnt       <= cnt_next;
      req_sent  <= req_sent_next;
      flip_ph   <= flip_ph_next;
      level     <= level_next;
      var_idx   <= var_idx_next;
      var_val   <= var_val_next;
      stk_clr   <= clr_next;
      stk_wr_en <= wr_next;
      stk_pop   <= pop_next;
      stk_din   <= din_next;
      eval_req  <= req_next;
      unassign  <= unas_next;
      busy      <= busy_next;
      sat       <= sat_next;
      unsat     <= unsat_next;
      err       <= err_next;
    end
  end

  // Every stack access detours through WAIT so the flags settle before use.
  always_comb begin
    state_next = state;
    ret_next   = ret;
    cnt_next   = cnt;
    case (state)
      S_IDLE, S_SAT, S_UNSAT, S_ERR: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        state_next = S_WAIT;
        ret_next   = S_DECIDE;
        cnt_next   = SETTLE_M1;
      end
      S_WAIT: begin
        if (cnt == '0) state_next = ret;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      S_DECIDE: begin
        if (at_end)        state_next = S_SAT;
        else if (stk_full) state_next = S_ERR;
        else begin
          state_next = S_WAIT;
          ret_next   = S_EVAL;
          cnt_next   = SETTLE_M1;
        end
      end
      S_EVAL: begin
        if (req_sent && eval_done) state_next = conflict ? S_BT_CHECK : S_DECIDE;
      end
      S_BT_CHECK: begin
        if (stk_empty)      state_next = S_UNSAT;
        else if (stk_front) state_next = S_BT_POP;
        else                state_next = S_FLIP;
      end
      S_BT_POP: begin
        state_next = S_WAIT;
        ret_next   = S_BT_CHECK;
        cnt_next   = SETTLE_M1;
      end
      S_FLIP: begin
        state_next = S_WAIT;
        ret_next   = flip_ph ? S_EVAL : S_FLIP;
        cnt_next   = SETTLE_M1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    level_next    = level;
    var_idx_next  = var_idx;
    var_val_next  = var_val;
    clr_next      = 1'b0;
    wr_next       = 1'b0;
    pop_next      = 1'b0;
    din_next      = 1'b0;
    req_next      = 1'b0;
    unas_next     = 1'b0;
    sat_next      = sat;
    unsat_next    = unsat;
    err_next      = err;
    req_sent_next = 1'b0;
    flip_ph_next  = flip_ph;
    busy_next     = !is_term(state_next);
    case (state)
      S_IDLE, S_SAT, S_UNSAT, S_ERR: begin
        if (state == S_SAT)   sat_next   = 1'b1;
        if (state == S_UNSAT) unsat_next = 1'b1;
        if (state == S_ERR)   err_next   = 1'b1;
        if (start) begin
          sat_next   = 1'b0;
          unsat_next = 1'b0;
          err_next   = 1'b0;
          level_next = '0;
        end
      end
      S_CLEAR: begin
        clr_next     = 1'b1;
        flip_ph_next = 1'b0;
      end
      S_DECIDE: begin
        if (!at_end && !stk_full) begin
          wr_next      = 1'b1;
          var_idx_next = level;
          var_val_next = 1'b0;
          level_next   = level + VAR_W'(1);
        end
      end
      S_EVAL: begin
        req_next      = !req_sent;
        req_sent_next = !(req_sent && eval_done);
      end
      S_BT_POP: begin
        pop_next     = 1'b1;
        unas_next    = 1'b1;
        var_idx_next = level - VAR_W'(1);
        level_next   = level - VAR_W'(1);
      end
      S_FLIP: begin
        // Pop the 0 and push a 1 for the same variable; level nets to zero change.
        if (!flip_ph) begin
          pop_next     = 1'b1;
          unas_next    = 1'b1;
          var_idx_next = level - VAR_W'(1);
          flip_ph_next = 1'b1;
        end else begin
          wr_next      = 1'b1;
          din_next     = 1'b1;
          var_val_next = 1'b1;
          flip_ph_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dpll_backtrack_ctrl.sv
`default_nettype none
// Scoreboard bench for dpll_backtrack_ctrl with a behavioural stack and evaluator.
module tb_dpll_backtrack_ctrl;
  localparam int NV = 3;
  localparam int VW = 5;
  localparam int ST = 2;
  localparam int STK_SIZE = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic eval_done = 1'b0;
  logic conflict = 1'b0;
  logic stk_front, stk_empty, stk_full;
  logic stk_clr, stk_wr_en, stk_pop, stk_din, eval_req, unassign, var_val;
  logic busy, sat, unsat, err;
  logic [VW-1:0] var_idx, level;

  dpll_backtrack_ctrl #(.NUM_VARS(NV), .VAR_W(VW), .SETTLE(ST)) dut (
    .clock(clock), .reset(reset), .start(start), .eval_done(eval_done),
    .conflict(conflict), .stk_front(stk_front), .stk_empty(stk_empty),
    .stk_full(stk_full), .stk_clr(stk_clr), .stk_wr_en(stk_wr_en),
    .stk_pop(stk_pop), .stk_din(stk_din), .eval_req(eval_req),
    .unassign(unassign), .var_idx(var_idx), .var_val(var_val), .level(level),
    .busy(busy), .sat(sat), .unsat(unsat), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stack model; the top level clears it on reset or stk_clr.
  logic [STK_SIZE-1:0] stk_mem = '0;
  int   stk_cnt = 0;
  logic force_full = 1'b0;
  always @(posedge clock) begin
    if (reset || stk_clr) stk_cnt <= 0;
    else if (stk_wr_en && stk_cnt < STK_SIZE) begin
      stk_mem[stk_cnt] <= stk_din;
      stk_cnt <= stk_cnt + 1;
    end else if (stk_pop && stk_cnt > 0) stk_cnt <= stk_cnt - 1;
  end
  assign stk_empty = (stk_cnt == 0);
  assign stk_front = (stk_cnt == 0) ? 1'b0 : stk_mem[stk_cnt-1];
  assign stk_full  = force_full || (stk_cnt == STK_SIZE);

  int pass_cnt = 0;
  int total_cnt = 0;
  int clr_count = 0;
  int start_cyc = 0;
  logic [VW+1:0] sb[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [VW+1:0] ev(input logic u, input int idx, input logic v);
    return {u, VW'(idx), v};
  endfunction

  // Monitor: every eval_req/unassign pops one expected event.
  always @(negedge clock) begin : monitor
    logic [VW+1:0] got;
    if (stk_clr) clr_count++;
    if (eval_req || unassign) begin
      got = {unassign, var_idx, unassign ? 1'b0 : var_val};
      if (sb.size() == 0) check("unexpected event", int'(got), -1);
      else check("event {unassign,idx,val}", int'(got), int'(sb.pop_front()));
      check("eval_req/unassign exclusive", int'(eval_req & unassign), 0);
    end
    if (stk_wr_en || stk_pop) check("push/pop exclusive", int'(stk_wr_en & stk_pop), 0);
  end

  // Evaluator model; mode 4 answers var 1 late so a reset can land in EVAL.
  int   mode = 0;
  int   ev_n = 0;
  logic asg0 = 1'b0;
  initial begin : evaluator
    forever begin
      @(negedge clock);
      if (eval_req && !reset) begin : resp
        logic [VW-1:0] i;
        logic v, c;
        int d;
        i = var_idx;
        v = var_val;
        if (i == 0) asg0 = v;
        case (mode)
          1:       c = (i == 1 && v == 1'b0);
          2:       c = 1'b1;
          3:       c = !asg0 && (i == 2 || (i == 1 && v == 1'b0));
          default: c = 1'b0;
        endcase
        d = (mode == 4 && i == 1) ? 10 : 1 + (ev_n % 3);
        ev_n++;
        repeat (d) @(negedge clock);
        eval_done = 1'b1;
        conflict  = c;
        @(negedge clock);
        eval_done = 1'b0;
        conflict  = 1'b0;
      end
    end
  end

  task automatic do_start();
    clr_count = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    start_cyc = cyc;
    check("flags cleared by start", int'({sat, unsat, err}), 0);
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (sat || unsat || err) break;
    end
    if (!(sat || unsat || err)) check({name, " timeout"}, 0, 1);
    @(negedge clock);
  endtask

  task automatic end_check(input string name, input logic [2:0] flags, input int lvl,
                           input int cnt, input int bits);
    int b;
    b = 0;
    for (int k = 0; k < stk_cnt && k < STK_SIZE; k++) b |= int'(stk_mem[k]) << k;
    check({name, " sat/unsat/err"}, int'({sat, unsat, err}), int'(flags));
    check({name, " level"}, int'(level), lvl);
    check({name, " stack depth"}, stk_cnt, cnt);
    check({name, " stack bits"}, b, bits);
    check({name, " busy"}, int'(busy), 0);
    check({name, " events left"}, sb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t_clr, t_wr, t_req;
    repeat (3) @(negedge clock);
    check("reset outputs", int'({stk_clr, stk_wr_en, stk_pop, stk_din, eval_req, unassign,
          var_idx, var_val, level, busy, sat, unsat, err}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // No conflicts, plus start-to-strobe latency.
    mode = 0;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(0, 1, 0)); sb.push_back(ev(0, 2, 0));
    do_start();
    t_clr = -1; t_wr = -1; t_req = -1;
    for (int i = 0; i < 40 && t_req < 0; i++) begin
      @(negedge clock);
      if (stk_clr && t_clr < 0) t_clr = cyc;
      if (stk_wr_en && t_wr < 0) t_wr = cyc;
      if (eval_req && t_req < 0) t_req = cyc;
    end
    check("stk_clr latency", t_clr - start_cyc, 1);
    check("first push latency", t_wr - start_cyc, 2 + ST);
    check("first eval_req latency", t_req - start_cyc, 3 + 2 * ST);
    wait_result("no-conflict");
    end_check("no-conflict", 3'b100, 3, 3, 0);
    check("no-conflict clr pulses", clr_count, 1);

    // Single conflict on (1,0); a start while busy must be ignored.
    mode = 1;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(0, 1, 0)); sb.push_back(ev(1, 1, 0));
    sb.push_back(ev(0, 1, 1)); sb.push_back(ev(0, 2, 0));
    do_start();
    repeat (10) @(negedge clock);
    check("busy mid-run", int'(busy), 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_result("single-conflict");
    end_check("single-conflict", 3'b100, 3, 3, 3'b010);
    check("busy start ignored clr pulses", clr_count, 1);

    // Always conflict.
    mode = 2;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(1, 0, 0));
    sb.push_back(ev(0, 0, 1)); sb.push_back(ev(1, 0, 0));
    do_start();
    wait_result("always-conflict");
    end_check("always-conflict", 3'b010, 0, 0, 0);

    // Deep backtrack, launched straight from UNSAT.
    mode = 3;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(0, 1, 0)); sb.push_back(ev(1, 1, 0));
    sb.push_back(ev(0, 1, 1)); sb.push_back(ev(0, 2, 0)); sb.push_back(ev(1, 2, 0));
    sb.push_back(ev(0, 2, 1)); sb.push_back(ev(1, 2, 0)); sb.push_back(ev(1, 1, 0));
    sb.push_back(ev(1, 0, 0)); sb.push_back(ev(0, 0, 1)); sb.push_back(ev(0, 1, 0));
    sb.push_back(ev(0, 2, 0));
    do_start();
    wait_result("deep-backtrack");
    end_check("deep-backtrack", 3'b100, 3, 3, 3'b001);
    check("restart after unsat clr pulses", clr_count, 1);

    // Full stack at the first decision is a misconfiguration.
    force_full = 1'b1;
    do_start();
    wait_result("stack-full");
    end_check("stack-full", 3'b001, 0, 0, 0);
    force_full = 1'b0;

    // Reset while waiting in EVAL at level 2.
    mode = 4;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(0, 1, 0));
    do_start();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("pre-reset level", int'(level), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid-run reset outputs", int'({stk_clr, stk_wr_en, stk_pop, stk_din, eval_req,
          unassign, var_idx, var_val, level, busy, sat, unsat, err}), 0);
    repeat (20) @(negedge clock);
    check("stray eval_done ignored", int'({busy, level, sat, unsat, err}), 0);
    mode = 0;
    sb.push_back(ev(0, 0, 0)); sb.push_back(ev(0, 1, 0)); sb.push_back(ev(0, 2, 0));
    do_start();
    wait_result("replay");
    end_check("replay", 3'b100, 3, 3, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
